// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding, parity selectors and the minimum bit period.
// Used by the TX frame generator and the RX parity checker alike.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int MIN_PRESCALE = 4;

    // Even parity is the XOR of the data bits; odd parity is its complement.
    function automatic logic frame_parity(input logic data_xor, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts clamped-Prescale cycles while enabled; bit_done is combinational, high in a bit's last cycle.
// No backpressure; the count is held at zero whenever enable is low.
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_done
);

    logic [PRESCALE_W-1:0] bit_cnt;
    logic [PRESCALE_W-1:0] period_last;

    // Periods shorter than MIN_PRESCALE are stretched rather than rejected.
    always_comb begin
        period_last = prescale - 1'b1;
        if (prescale < PRESCALE_W'(MIN_PRESCALE)) begin
            period_last = PRESCALE_W'(MIN_PRESCALE - 1);
        end
    end

    assign bit_done = enable && (bit_cnt == period_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt <= '0;
        end else if (!enable || bit_done) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART TX: start, DATA_WIDTH bits LSB first, optional parity, stop; start bit appears the clk after Data_Valid.
// Data_Valid is ignored while busy (no queuing); UART_TX_STOP2_EN selects two stop bits.
module uart_tx_frame_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_t           state;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_en_reg;
    logic                  parity_reg;
    logic [PRESCALE_W-1:0] prescale_reg;
    logic [IDX_W-1:0]      idx;
    logic                  bit_done;
`ifdef UART_TX_STOP2_EN
    logic                  stop_second;
`endif

    uart_tx_bit_timer #(
        .PRESCALE_W (PRESCALE_W)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .enable   (busy),
        .prescale (prescale_reg),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            data_reg     <= '0;
            par_en_reg   <= 1'b0;
            parity_reg   <= 1'b0;
            prescale_reg <= '0;
            idx          <= '0;
            TX_OUT       <= 1'b1;
            busy         <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop_second  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                    if (Data_Valid) begin
                        // Frame is fully described by these latches; later input changes are ignored.
                        data_reg     <= P_DATA;
                        par_en_reg   <= PAR_EN;
                        parity_reg   <= frame_parity(^P_DATA, PAR_TYP);
                        prescale_reg <= Prescale;
                        state        <= START;
                        TX_OUT       <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state  <= DATA;
                        idx    <= '0;
                        TX_OUT <= data_reg[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (idx == IDX_W'(DATA_WIDTH - 1)) begin
                            if (par_en_reg) begin
                                state  <= PARITY;
                                TX_OUT <= parity_reg;
                            end else begin
                                state  <= STOP;
                                TX_OUT <= 1'b1;
                            end
                        end else begin
                            idx    <= idx + 1'b1;
                            TX_OUT <= data_reg[idx + 1'b1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
`ifdef UART_TX_STOP2_EN
                        if (!stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            stop_second <= 1'b0;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen: captures each frame cycle by cycle and checks bit values, timing and idle gaps.
module tb_uart_tx_frame_gen;

`ifdef UART_TX_STOP2_EN
    localparam int XSTOP = 1;
`else
    localparam int XSTOP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic       TX_OUT;
    logic       busy;

    int passed = 0;
    int failed = 0;
    logic line_q[$];

    uart_tx_frame_gen #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a request at a negedge; returns at the first START cycle (after the sampling edge).
    task automatic start_frame(input logic [7:0] d, input logic [5:0] ps, input logic pe, input logic pt);
        P_DATA     = d;
        Prescale   = ps;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
    endtask

    task automatic capture(output int len);
        int n;
        n = 0;
        line_q.delete();
        while (busy === 1'b1 && n < 4000) begin
            line_q.push_back(TX_OUT);
            @(negedge clk);
            n++;
        end
        len = n;
    endtask

    task automatic verify(input string tag, input logic [7:0] d, input int pl, input logic pe,
                          input logic exp_par, input int len);
        int   nb;
        int   pos;
        int   mism;
        logic expb;
        logic obsb;
        nb = 10 + int'(pe) + XSTOP;
        chk({tag, "_len"}, len, nb * pl);
        for (int b = 0; b < nb; b++) begin
            if (b == 0)                expb = 1'b0;
            else if (b <= 8)           expb = d[b-1];
            else if (pe && b == 9)     expb = exp_par;
            else                       expb = 1'b1;
            pos  = b * pl + pl / 2;
            obsb = (pos < line_q.size()) ? line_q[pos] : 1'bx;
            chk($sformatf("%s_bit%0d", tag, b), obsb, expb);
        end
        mism = 0;
        for (int i = 0; i < line_q.size(); i++) begin
            if (line_q[i] !== line_q[(i / pl) * pl]) mism++;
        end
        chk({tag, "_stable"}, mism, 0);
        chk({tag, "_idle_tx"}, TX_OUT, 1'b1);
        chk({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        int len;

        // Reset held with a pending request: line must stay idle.
        rst        = 1'b0;
        Data_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_tx%0d", i), TX_OUT, 1'b1);
            chk($sformatf("rst_busy%0d", i), busy, 1'b0);
        end
        Data_Valid = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_tx", TX_OUT, 1'b1);
        chk("idle_busy", busy, 1'b0);

        // 0xA5, even parity (four ones -> 0).
        start_frame(8'hA5, 6'd8, 1'b1, 1'b0);
        capture(len);
        verify("a5_even", 8'hA5, 8, 1'b1, 1'b0, len);

        // 0x00, odd parity (-> 1); inputs scrambled mid-frame must not matter.
        start_frame(8'h00, 6'd16, 1'b1, 1'b1);
        P_DATA   = 8'hFF;
        Prescale = 6'd5;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        capture(len);
        verify("z_odd", 8'h00, 16, 1'b1, 1'b1, len);

        // Back-to-back frames with Data_Valid held high.
        @(negedge clk);
        start_frame(8'h3C, 6'd8, 1'b0, 1'b0);
        Data_Valid = 1'b1;
        P_DATA     = 8'hC3;
        capture(len);
        verify("b2b_f1", 8'h3C, 8, 1'b0, 1'b0, len);
        @(negedge clk);
        chk("b2b_gap_busy", busy, 1'b1);
        chk("b2b_gap_tx", TX_OUT, 1'b0);
        Data_Valid = 1'b0;
        capture(len);
        verify("b2b_f2", 8'hC3, 8, 1'b0, 1'b0, len);

        // Reset during DATA bit 3 (cycles 32..39 of the frame).
        @(negedge clk);
        start_frame(8'h55, 6'd8, 1'b0, 1'b0);
        repeat (34) @(negedge clk);
        chk("mid_bit3", TX_OUT, 1'b0);
        chk("mid_busy", busy, 1'b1);
        rst        = 1'b0;
        Data_Valid = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", TX_OUT, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        rst        = 1'b1;
        Data_Valid = 1'b0;
        @(negedge clk);
        chk("post_rst_tx", TX_OUT, 1'b1);
        chk("post_rst_busy", busy, 1'b0);

        // Clean frame after reset: 0x01, no parity, 16-cycle bits.
        start_frame(8'h01, 6'd16, 1'b0, 1'b0);
        capture(len);
        verify("x01_nopar", 8'h01, 16, 1'b0, 1'b0, len);

        // Prescale below minimum clamps to 4-cycle bits.
        @(negedge clk);
        start_frame(8'h0F, 6'd2, 1'b0, 1'b0);
        capture(len);
        verify("clamp", 8'h0F, 4, 1'b0, 1'b0, len);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, passed + failed);
        $finish;
    end

endmodule
